// File: rtl/wb_collector.sv
// Writeback collector: claims up to wbw unit results per cycle, with
// round-robin fairness across units and in-order lanes within a unit.
package wb_pkg;
  typedef struct packed {
    logic [15:0] opid;
    logic [4:0]  rd;
    logic [31:0] data;
  } exe_bundle_t;
endpackage

module wb_collector
  import wb_pkg::*;
#(
  parameter int nfu = 4,
  parameter int ewd = 4,
  parameter int wbw = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  exe_bundle_t [nfu-1:0][ewd-1:0] resp,
  output logic [nfu-1:0][ewd-1:0]      claim,
  input  logic                         stall,
  output exe_bundle_t [wbw-1:0]        wb,
  output logic [$clog2(wbw):0]         wb_num
);

  localparam int PW = (nfu > 1) ? $clog2(nfu) : 1;
  localparam int NW = $clog2(wbw) + 1;
  localparam int SW = (wbw > 1) ? $clog2(wbw) : 1;

  logic [PW-1:0]        rr_ptr;
  logic [63:0]          wb_total;
  logic [nfu-1:0][ewd-1:0] claim_n;
  exe_bundle_t [wbw-1:0] wb_n;
  logic [NW-1:0]        cnt;
  logic [PW:0]          u_sum;
  logic [PW-1:0]        u;
  logic                 blk;

  // A lane past the first unclaimed lane of its unit stays blocked
  always_comb begin
    claim_n = '0;
    wb_n    = '0;
    cnt     = '0;
    u_sum   = '0;
    u       = '0;
    blk     = 1'b0;
    if (!(rst || flush || stall)) begin
      for (int i = 0; i < nfu; i++) begin
        u_sum = {1'b0, rr_ptr} + (PW+1)'(i);
        if (u_sum >= (PW+1)'(nfu))
          u_sum = u_sum - (PW+1)'(nfu);
        u   = u_sum[PW-1:0];
        blk = 1'b0;
        for (int j = 0; j < ewd; j++) begin
          if (!blk && resp[u][j].opid[15]
              && cnt < NW'(wbw)) begin
            claim_n[u][j]     = 1'b1;
            wb_n[cnt[SW-1:0]] = resp[u][j];
            cnt               = cnt + NW'(1);
          end else begin
            blk = 1'b1;
          end
        end
      end
    end
  end

  assign claim = claim_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb       <= '0;
      wb_num   <= '0;
      rr_ptr   <= '0;
      wb_total <= '0;
    end else if (flush) begin
      wb     <= '0;
      wb_num <= '0;
      rr_ptr <= '0;
    end else if (!stall) begin
      wb       <= wb_n;
      wb_num   <= cnt;
      wb_total <= wb_total + 64'(cnt);
      if (cnt != '0)
        rr_ptr <= (rr_ptr == PW'(nfu - 1)) ? '0
                                          : rr_ptr + PW'(1);
    end
  end

endmodule

// File: doc/wb_collector.md
Name: wb_collector

Overview:
- Writeback-side consumer of the execution-unit result interface: the `resp`/`claim` end driven by the FPU, ALU, LSU and similar units.
- Each cycle it selects up to `wbw` valid results across all functional units and asserts `claim` for exactly those lanes.
- Selected results are compacted into a registered writeback bundle that feeds register-file write and ROB completion.
- Unit fairness is round-robin; within a unit, lanes are taken strictly in order.

Parameters:
- nfu, 4, number of functional units connected.
- ewd, 4, result lanes per unit (matches unit `ewd`).
- wbw, 4, writeback slots per cycle.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  pipeline flush; synchronous.
- resp  input  [nfu-1:0][ewd-1:0] exe_bundle_t  unit results; a lane is valid when opid[15]=1.
- claim  output  [nfu-1:0][ewd-1:0]  combinational; 1 = lane consumed this cycle.
- stall  input  1  downstream cannot accept a new writeback bundle.
- wb  output  [wbw-1:0] exe_bundle_t  registered writeback bundle; a slot is valid when opid[15]=1.
- wb_num  output  $clog2(wbw)+1  registered count of valid `wb` slots.

Behaviour:
- Reset values (rst=1, or flush=1 at the clock edge):
  - wb = 0 and wb_num = 0.
  - rr_ptr = 0.
  - The 64-bit internal counter `wb_total` = 0 on rst only; it is not cleared by flush.
- claim is forced to all-zero whenever any of rst, flush or stall is 1.
- Selection (combinational, when rst=flush=stall=0):
  - Visit units in order rr_ptr, rr_ptr+1, ..., rr_ptr+nfu-1, all mod nfu.
  - Within each unit, visit lanes 0..ewd-1.
  - Lane j of unit u is eligible only if lanes 0..j-1 of unit u are all valid and claimed this cycle. The first invalid or unclaimed lane blocks higher lanes of that unit.
  - Eligible valid lanes are taken in visiting order until wbw slots are filled.
  - claim[u][j]=1 exactly for the taken lanes.
  - An invalid lane is never claimed.
- Compaction: taken results occupy wb slots 0..k-1 in visiting order; slots k..wbw-1 are written 0.
- Register update:
  - When stall=0, on posedge: wb <= compacted bundle, wb_num <= k, wb_total <= wb_total + k.
  - When stall=1: wb, wb_num, wb_total and rr_ptr hold.
- Latency: a result claimed in cycle N appears in wb in cycle N+1.
- Round-robin: if k>0 and stall=0, rr_ptr <= (rr_ptr+1) mod nfu. If k=0, rr_ptr holds.
- No stall-through: a unit that sees claim=0 must keep presenting its result. The collector never drops a valid lane without claiming it.
- Simultaneous flush and stall: flush wins; wb is cleared.
- Width rules:
  - k is at most min(wbw, nfu*ewd).
  - rr_ptr is $clog2(nfu) bits wide and wraps explicitly at nfu, so wrap is correct for non-power-of-two nfu.
  - wb_num is wide enough to hold the value wbw.

Test Plan:
- Single unit, in-order lanes: unit 0 lanes 0..3 valid (opids 0x8001..0x8004), others invalid, wbw=4 → claim[0]=4'b1111; next cycle wb opids 0x8001..0x8004, wb_num=4.
- Lane gap: unit 1 lanes 0 and 2 valid, lane 1 invalid → claim[1]=4'b0001; lane 2 not claimed until lane 1 is resolved; wb_num=1, result in slot 0.
- Over-subscription and fairness: all 4 units present 4 valid lanes each, rr_ptr=0 → cycle 1 claims unit 0 lanes 0..3 only, rr_ptr→1; cycle 2 claims unit 1; sustained load gives each unit exactly 4 claims per 4 cycles.
- Mixed packing, wbw=4: unit 2 has 3 valid lanes, unit 3 has 2 valid lanes, rr_ptr=2 → claim unit 2 lanes 0..2 and unit 3 lane 0; wb slots are u2l0, u2l1, u2l2, u3l0.
- Stall: assert stall for 3 cycles with valid results present → claim=0 throughout; wb, wb_num and rr_ptr hold; after release, claims resume with the same rr_ptr.
- Flush/reset mid-operation: flush while wb_num=3 and stall=1 → next cycle wb=0, wb_num=0, rr_ptr=0, no claims that cycle, wb_total unchanged. A subsequent rst clears wb_total to 0.
